// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   - loader_state_e : sequencer states
//   - BYTES_PER_WORD : bytes assembled into one instruction word
//   - word_to_byte_addr() : word index -> byte address conversion
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_SHIFT     = $clog2(BYTES_PER_WORD);

  // Instruction memory is word-addressed internally but the write port
  // carries byte addresses, so the word index is scaled by the word size.
  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
    return word_idx << BYTE_SHIFT;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake and the instruction-memory write port.
//   in_valid / in_data / in_ready : incoming byte stream
//   mem_we / mem_addr / mem_wdata : instruction-memory write port
// Modports:
//   master : the environment (drives bytes, observes memory writes)
//   slave  : the loader (accepts bytes, drives memory writes)
// -----------------------------------------------------------------------------
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_byte_packer
// Assembles accepted bytes into a 32-bit little-endian word (first byte lands
// in bits [7:0]).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart a new group (position and partial word to zero)
//   accept     : a byte is taken this cycle
//   byte_in    : the byte being taken
//   word_next  : the word as it will look once byte_in is shifted in
//   word_full  : this accept completes the 4-byte group
// -----------------------------------------------------------------------------
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  // Only the three most recent bytes need storing: the oldest byte of a
  // full word is still present in the low lane of word_next when the fourth
  // byte arrives.
  logic [23:0] shift_r;
  logic [1:0]  pos_r;

  assign word_next = {byte_in, shift_r};
  assign word_full = accept && (pos_r == 2'd3);

  // Shift register and byte position within the current group.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_r <= 24'd0;
      pos_r   <= 2'd0;
    end else if (accept) begin
      shift_r <= word_next[31:8];
      pos_r   <= pos_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      pos_r   <= pos_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot sequencer: reads a little-endian word count N followed by N
// little-endian words from a byte stream, writes them to consecutive word
// addresses from 0, and releases the core once the whole image is resident.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : load request pulse (honoured in IDLE and DONE only)
//   bus        : byte stream in, instruction-memory write port out
//   core_stall : holds core fetch until a load completes
//   done       : image fully written
//   err        : header count exceeded MAX_WORDS (sticky until rst)
// All outputs are registered; they are computed from the next state so they
// line up with the state they describe.
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  imem_loader_if.slave       bus,
  output logic               core_stall,
  output logic               done,
  output logic               err
);

  localparam int          IDX_W       = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  loader_state_e state_r;
  loader_state_e state_next_s;

  logic [31:0]      count_r;
  logic [IDX_W-1:0] word_idx_r;
  logic [31:0]      idx_ext_s;
  logic             is_last_s;

  logic        accept_s;
  logic        clear_s;
  logic [31:0] word_next_s;
  logic        word_full_s;

  logic        in_ready_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        core_stall_r;
  logic        done_r;
  logic        err_r;

  // in_ready_r is high exactly when the state is LEN or DATA, so it doubles
  // as the byte-acceptance qualifier.
  assign accept_s  = bus.in_valid && in_ready_r;
  assign idx_ext_s = 32'(word_idx_r);
  assign is_last_s = (idx_ext_s == (count_r - 32'd1));

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .accept    (accept_s),
    .byte_in   (bus.in_data),
    .word_next (word_next_s),
    .word_full (word_full_s)
  );

  // Next-state logic for the load sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LEN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LEN: begin
        // Count is judged on the completed word, including the byte taken now.
        if (word_full_s) begin
          if (word_next_s == 32'd0) begin
            state_next_s = ST_DONE;
          end else if (word_next_s > MAX_WORDS_W) begin
            state_next_s = ST_ERR;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (word_full_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (is_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next_s = ST_LEN;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_ERR: begin
        state_next_s = ST_ERR;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Byte position restarts whenever a new byte group (count or data word) begins.
  always_comb begin
    clear_s = 1'b0;
    if ((state_next_s == ST_LEN) && (state_r != ST_LEN)) begin
      clear_s = 1'b1;
    end else if ((state_next_s == ST_DATA) && (state_r != ST_DATA)) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
  end

  // State register, captured word count and current word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      count_r    <= 32'd0;
      word_idx_r <= '0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_LEN) && word_full_s) begin
        count_r <= word_next_s;
      end else begin
        count_r <= count_r;
      end
      if ((state_next_s == ST_LEN) && (state_r != ST_LEN)) begin
        word_idx_r <= '0;
      end else if ((state_r == ST_WRITE) && (state_next_s == ST_DATA)) begin
        word_idx_r <= word_idx_r + IDX_W'(1);
      end else begin
        word_idx_r <= word_idx_r;
      end
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      core_stall_r <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      in_ready_r   <= (state_next_s == ST_LEN) || (state_next_s == ST_DATA);
      mem_we_r     <= (state_next_s == ST_WRITE);
      core_stall_r <= (state_next_s != ST_DONE);
      done_r       <= (state_next_s == ST_DONE);
      err_r        <= (state_next_s == ST_ERR);
      // Address/data only move on a write so they hold between strobes.
      if (state_next_s == ST_WRITE) begin
        mem_addr_r  <= word_to_byte_addr(idx_ext_s);
        mem_wdata_r <= word_next_s;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign core_stall    = core_stall_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. A stream-level model turns each byte image
// into the list of (address, word) writes it must produce; a monitor checks
// every mem_we pulse against that list. Directed checks cover reset values,
// handshake timing, empty/oversize/boundary headers and reset mid-load.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int MAX_WORDS = 1024;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic core_stall;
  logic done;
  logic err;

  imem_loader_if bus ();

  imem_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .core_stall (core_stall),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Stream model: header N, then only complete words up to N are written.
  function automatic void model_load(input byte_q_t b);
    logic [31:0] n;
    int          avail;
    if (b.size() < 4) return;
    n = {b[3], b[2], b[1], b[0]};
    if (n == 32'd0 || n > 32'(MAX_WORDS)) return;
    avail = (b.size() - 4) / 4;
    for (int i = 0; i < avail && 32'(i) < n; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      exp_data_q.push_back({b[4*i+7], b[4*i+6], b[4*i+5], b[4*i+4]});
    end
  endfunction

  // Monitor: every write strobe must match the next modelled write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      check("we_one_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        check("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
        check("wr_data", bus.mem_wdata, exp_data_q.pop_front());
      end
    end
    prev_we = (bus.mem_we === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b);
    int   t;
    logic rdy;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      t++;
    end while (!rdy && t < 100);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte 0x%02h not accepted, expected accept within 100 cycles", b);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Sends an image; with gaps, idles 0..2 cycles before each byte, and can
  // drop a spurious start pulse in the middle of the load.
  task automatic send_image(input byte_q_t b, input bit gaps, input int start_at);
    for (int i = 0; i < b.size(); i++) begin
      if (i == start_at) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send_byte(b[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stall"}, {31'd0, core_stall}, 32'd1);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t img;
    byte_q_t part;
    img = '{8'h02, 8'h00, 8'h00, 8'h00,
            8'h13, 8'h00, 8'h00, 8'h00,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};

    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    do_reset();
    check_reset_values("reset");

    // Nominal load; pin the model against hand-computed writes first.
    model_load(img);
    check("model_count", 32'(exp_addr_q.size()), 32'd2);
    check("model_addr0", exp_addr_q[0], 32'h0000_0000);
    check("model_data0", exp_data_q[0], 32'h0000_0013);
    check("model_addr1", exp_addr_q[1], 32'h0000_0004);
    check("model_data1", exp_data_q[1], 32'hDEAD_BEEF);
    pulse_start();
    check("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("start_stall", {31'd0, core_stall}, 32'd1);
    send_image(img, 1'b0, -1);
    check("nom_last_we", {31'd0, bus.mem_we}, 32'd1);
    check("nom_last_addr", bus.mem_addr, 32'h0000_0004);
    check("nom_last_data", bus.mem_wdata, 32'hDEAD_BEEF);
    check("nom_done_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("nom_done", {31'd0, done}, 32'd1);
    check("nom_stall", {31'd0, core_stall}, 32'd0);
    check("nom_we_low", {31'd0, bus.mem_we}, 32'd0);
    check("nom_hold_addr", bus.mem_addr, 32'h0000_0004);
    check("nom_writes_left", 32'(exp_addr_q.size()), 32'd0);

    // Restart from DONE with gaps, backpressure and an ignored start mid-load.
    model_load(img);
    pulse_start();
    check("restart_done_cleared", {31'd0, done}, 32'd0);
    check("restart_stall", {31'd0, core_stall}, 32'd1);
    send_image(img, 1'b1, 6);
    @(posedge clk);
    #1;
    check("bp_done", {31'd0, done}, 32'd1);
    check("bp_writes_left", 32'(exp_addr_q.size()), 32'd0);

    // Empty image.
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    model_load(img);
    pulse_start();
    send_image(img, 1'b0, -1);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_stall", {31'd0, core_stall}, 32'd0);
    check("empty_we", {31'd0, bus.mem_we}, 32'd0);
    check("empty_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // Oversize header: MAX_WORDS+1.
    img = '{8'h01, 8'h04, 8'h00, 8'h00};
    model_load(img);
    pulse_start();
    send_image(img, 1'b0, -1);
    check("over_err", {31'd0, err}, 32'd1);
    check("over_stall", {31'd0, core_stall}, 32'd1);
    check("over_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("over_done", {31'd0, done}, 32'd0);
    check("over_we", {31'd0, bus.mem_we}, 32'd0);
    pulse_start();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("over_sticky_err", {31'd0, err}, 32'd1);
    check("over_sticky_in_ready", {31'd0, bus.in_ready}, 32'd0);

    do_reset();
    check_reset_values("err_reset");

    // Boundary header N == MAX_WORDS is accepted and data collection begins.
    img = '{8'h00, 8'h04, 8'h00, 8'h00};
    model_load(img);
    pulse_start();
    send_image(img, 1'b0, -1);
    check("max_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("max_err", {31'd0, err}, 32'd0);
    check("max_done", {31'd0, done}, 32'd0);
    do_reset();

    // Reset after the 2nd data byte of word 1: only word 0 is written.
    img = '{8'h02, 8'h00, 8'h00, 8'h00,
            8'h13, 8'h00, 8'h00, 8'h00,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    part = img[0:9];
    model_load(part);
    pulse_start();
    send_image(part, 1'b0, -1);
    do_reset();
    check_reset_values("midload");
    check("midload_writes_left", 32'(exp_addr_q.size()), 32'd0);

    model_load(img);
    pulse_start();
    send_image(img, 1'b0, -1);
    @(posedge clk);
    #1;
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_writes_left", 32'(exp_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
